// File: rtl/fpu_issue.sv
// ---------------------------------------------------------------------------
// fpu_issue -- issue/sequencing stage sitting directly in front of the fpu.
//
// Takes one floating-point request at a time from execute, holds its operands
// and opcode steady on the fpu inputs until the fpu signals completion, then
// offers the tagged result to writeback. Requests with an unknown opcode skip
// the fpu entirely. Requests the fpu never finishes are aborted after TIMEOUT
// cycles. Both cases are reported through wb_err.
//
// Parameters
//   TIMEOUT : number of EXEC cycles allowed before the request is aborted
//   RD_W    : width of the destination register index
//
// Ports
//   clk, rstn                      clock, synchronous active-low reset
//   req_valid/req_ready            request handshake from execute
//   req_src0, req_src1, req_op,    request payload (operands, fpu opcode,
//   req_rd                         destination register)
//   fpu_src0, fpu_src1, fpu_op     operands/opcode driven into the fpu
//   fpu_result, fpu_fin            result and completion strobe from the fpu
//   wb_valid/wb_ready              result handshake to writeback
//   wb_data, wb_rd, wb_to_int,     result payload; wb_to_int selects the
//   wb_err                         integer register file, wb_err[0] illegal
//                                  opcode, wb_err[1] timeout
//   busy                           request in flight (EXEC or WB)
// ---------------------------------------------------------------------------
module fpu_issue #(
    parameter int TIMEOUT = 15,
    parameter int RD_W    = 5
) (
    input  logic            clk,
    input  logic            rstn,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic [31:0]     req_src0,
    input  logic [31:0]     req_src1,
    input  logic [3:0]      req_op,
    input  logic [RD_W-1:0] req_rd,

    output logic [31:0]     fpu_src0,
    output logic [31:0]     fpu_src1,
    output logic [3:0]      fpu_op,
    input  logic [31:0]     fpu_result,
    input  logic            fpu_fin,

    output logic            wb_valid,
    input  logic            wb_ready,
    output logic [31:0]     wb_data,
    output logic [RD_W-1:0] wb_rd,
    output logic            wb_to_int,
    output logic [1:0]      wb_err,

    output logic            busy
);

    // Counter must reach TIMEOUT-1; one extra bit of headroom keeps the
    // width valid for any TIMEOUT >= 1.
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [3:0] OP_NOP      = 4'b1111;
    localparam logic [3:0] OP_LAST     = 4'b1010;   // highest legal opcode
    localparam logic [3:0] OP_INT_BASE = 4'b1000;   // first int-destination op

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    state_t            state_reg;
    logic [31:0]       src0_reg;
    logic [31:0]       src1_reg;
    logic [3:0]        op_reg;
    logic [RD_W-1:0]   rd_reg;
    logic              to_int_reg;
    logic [31:0]       data_reg;
    logic [1:0]        err_reg;
    logic [CNT_W-1:0]  cnt_reg;

    logic              accept;
    logic              req_legal;
    logic              req_to_int;

    // A new request may enter while idle, or in the very cycle the pending
    // result leaves, so back-to-back traffic sees no bubble. Held low during
    // reset so nothing is accepted while the stage is being cleared.
    assign req_ready = rstn & ((state_reg == ST_IDLE) |
                               ((state_reg == ST_WB) & wb_ready));
    assign accept    = req_valid & req_ready;

    assign req_legal  = (req_op <= OP_LAST);
    assign req_to_int = (req_op >= OP_INT_BASE) && (req_op <= OP_LAST);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg  <= ST_IDLE;
            src0_reg   <= '0;
            src1_reg   <= '0;
            op_reg     <= '0;
            rd_reg     <= '0;
            to_int_reg <= 1'b0;
            data_reg   <= '0;
            err_reg    <= ERR_NONE;
            cnt_reg    <= '0;
        end else begin
            case (state_reg)
                ST_EXEC: begin
                    // Completion wins over timeout when both land together.
                    if (fpu_fin) begin
                        data_reg  <= fpu_result;
                        err_reg   <= ERR_NONE;
                        state_reg <= ST_WB;
                    end else if (cnt_reg == CNT_LAST) begin
                        data_reg  <= '0;
                        err_reg   <= ERR_TIMEOUT;
                        state_reg <= ST_WB;
                    end else begin
                        cnt_reg   <= cnt_reg + CNT_W'(1);
                    end
                end

                default: begin
                    // IDLE and WB share the accept path; req_ready already
                    // encodes which of the two may take a new request.
                    if (accept) begin
                        src0_reg   <= req_src0;
                        src1_reg   <= req_src1;
                        op_reg     <= req_op;
                        rd_reg     <= req_rd;
                        to_int_reg <= req_to_int;
                        data_reg   <= '0;
                        cnt_reg    <= '0;
                        if (req_legal) begin
                            err_reg   <= ERR_NONE;
                            state_reg <= ST_EXEC;
                        end else begin
                            err_reg   <= ERR_ILLEGAL;
                            state_reg <= ST_WB;
                        end
                    end else if ((state_reg == ST_WB) && wb_ready) begin
                        state_reg <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Outside EXEC the fpu must see NOP: any real multi-cycle opcode would
    // start its internal counter even though nobody is waiting for it.
    assign fpu_op    = (state_reg == ST_EXEC) ? op_reg : OP_NOP;
    assign fpu_src0  = src0_reg;
    assign fpu_src1  = src1_reg;

    assign wb_valid  = (state_reg == ST_WB);
    assign wb_data   = data_reg;
    assign wb_rd     = rd_reg;
    assign wb_to_int = to_int_reg;
    assign wb_err    = err_reg;

    assign busy      = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_fpu_issue.sv
// ---------------------------------------------------------------------------
// tb_fpu_issue -- directed self-checking bench for fpu_issue.
//
// A small behavioural fpu stand-in supplies fin after the opcode-dependent
// latency (fadd/fsub/fmul 4, fdiv 11, fsqrt 9, everything else 1) and only
// presents a meaningful result in the fin cycle. It can be told to hang so
// the timeout path is reachable.
// ---------------------------------------------------------------------------
module tb_fpu_issue;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_src0;
    logic [31:0] req_src1;
    logic [3:0]  req_op;
    logic [4:0]  req_rd;
    logic [31:0] fpu_src0;
    logic [31:0] fpu_src1;
    logic [3:0]  fpu_op;
    logic [31:0] fpu_result;
    logic        fpu_fin;
    logic        wb_valid;
    logic        wb_ready;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_to_int;
    logic [1:0]  wb_err;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    fpu_issue #(.TIMEOUT(15), .RD_W(5)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src0   (req_src0),
        .req_src1   (req_src1),
        .req_op     (req_op),
        .req_rd     (req_rd),
        .fpu_src0   (fpu_src0),
        .fpu_src1   (fpu_src1),
        .fpu_op     (fpu_op),
        .fpu_result (fpu_result),
        .fpu_fin    (fpu_fin),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_rd      (wb_rd),
        .wb_to_int  (wb_to_int),
        .wb_err     (wb_err),
        .busy       (busy)
    );

    // ---------------- fpu stand-in ----------------
    logic [31:0] stub_val;
    logic        stub_hang;
    int          stub_cnt;

    function automatic int stub_lat(input logic [3:0] op);
        case (op)
            4'b0000, 4'b0001, 4'b0010: stub_lat = 4;
            4'b0011:                   stub_lat = 11;  // fdiv
            4'b0100:                   stub_lat = 9;   // fsqrt
            default:                   stub_lat = 1;
        endcase
    endfunction

    assign fpu_fin    = (fpu_op == 4'hF) ? 1'b1
                      : (!stub_hang && (stub_cnt == stub_lat(fpu_op) - 1));
    assign fpu_result = (fpu_fin && fpu_op != 4'hF) ? stub_val : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (!rstn || fpu_op == 4'hF || fpu_fin)
            stub_cnt <= 0;
        else
            stub_cnt <= stub_cnt + 1;
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request, waits for it to reach writeback (bounded), and
    // reports how many EXEC cycles it spent and whether the fpu inputs stayed
    // on the latched values while execute scrambled its request lines.
    task automatic issue_and_wait(input logic [3:0] op, input logic [31:0] s0,
                                  input logic [31:0] s1, input logic [4:0] rd,
                                  output int cycles, output bit held,
                                  output bit ready_low);
        req_valid = 1'b1;
        req_op    = op;
        req_src0  = s0;
        req_src1  = s1;
        req_rd    = rd;
        tick();
        req_valid = 1'b0;
        req_op    = 4'h0;
        req_src0  = ~s0;
        req_src1  = 32'h0;
        req_rd    = ~rd;
        cycles    = 0;
        held      = 1'b1;
        ready_low = 1'b1;
        while (!wb_valid && cycles < 40) begin
            cycles++;
            if (fpu_op !== op || fpu_src0 !== s0 || fpu_src1 !== s1) held = 1'b0;
            if (req_ready !== 1'b0) ready_low = 1'b0;
            tick();
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rstn = 1'b0; req_valid = 1'b1; wb_ready = 1'b0;
        req_op = 4'h0; req_src0 = 32'h1; req_src1 = 32'h2; req_rd = 5'd1;
        stub_val = 32'h0; stub_hang = 1'b0;
        tick(); tick();
        total_cnt++;
        if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else pass_cnt++;
        total_cnt++;
        if (wb_valid !== 1'b0) $display("FAIL reset_wb_valid: got %b want 0", wb_valid); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (fpu_op !== 4'hF) $display("FAIL reset_fpu_op: got %h want f", fpu_op); else pass_cnt++;
        total_cnt++;
        if (fpu_src0 !== 32'h0 || fpu_src1 !== 32'h0)
            $display("FAIL reset_fpu_src: got %h/%h want 0/0", fpu_src0, fpu_src1); else pass_cnt++;
        total_cnt++;
        if (wb_err !== 2'b00 || wb_data !== 32'h0)
            $display("FAIL reset_wb_err_data: got %b/%h want 00/0", wb_err, wb_data); else pass_cnt++;
        req_valid = 1'b0;
        rstn = 1'b1;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b want 1", req_ready); else pass_cnt++;
        $display("reset: done");
    endtask

    task automatic test_fadd();
        int cyc; bit held; bit rlow;
        wb_ready = 1'b1;
        stub_val = 32'h40400000;
        issue_and_wait(4'b0000, 32'h3F800000, 32'h40000000, 5'd3, cyc, held, rlow);
        total_cnt++;
        if (cyc !== 4) $display("FAIL fadd_exec_cycles: got %0d want 4", cyc); else pass_cnt++;
        total_cnt++;
        if (!held) $display("FAIL fadd_fpu_inputs_held: got 0 want 1"); else pass_cnt++;
        total_cnt++;
        if (!rlow) $display("FAIL fadd_req_ready_low: got 0 want 1"); else pass_cnt++;
        total_cnt++;
        if (wb_data !== 32'h40400000) $display("FAIL fadd_wb_data: got %h want 40400000", wb_data); else pass_cnt++;
        total_cnt++;
        if (wb_rd !== 5'd3 || wb_to_int !== 1'b0 || wb_err !== 2'b00)
            $display("FAIL fadd_wb_tag: got rd=%0d int=%b err=%b want rd=3 int=0 err=00", wb_rd, wb_to_int, wb_err);
        else pass_cnt++;
        total_cnt++;
        if (fpu_op !== 4'hF) $display("FAIL fadd_wb_fpu_op: got %h want f", fpu_op); else pass_cnt++;
        tick();
        total_cnt++;
        if (wb_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL fadd_drain: got valid=%b busy=%b want 0/0", wb_valid, busy); else pass_cnt++;
        $display("fadd: cycles=%0d data=%h", cyc, wb_data);
    endtask

    task automatic test_fdiv_flt();
        int cyc; bit held; bit rlow;
        wb_ready = 1'b1;
        stub_val = 32'h40400000;
        issue_and_wait(4'b0011, 32'h40C00000, 32'h40000000, 5'd7, cyc, held, rlow);
        total_cnt++;
        if (cyc !== 11) $display("FAIL fdiv_exec_cycles: got %0d want 11", cyc); else pass_cnt++;
        total_cnt++;
        if (!rlow) $display("FAIL fdiv_req_ready_low: got 0 want 1"); else pass_cnt++;
        total_cnt++;
        if (wb_data !== 32'h40400000 || wb_rd !== 5'd7)
            $display("FAIL fdiv_wb: got %h rd=%0d want 40400000 rd=7", wb_data, wb_rd); else pass_cnt++;
        $display("fdiv: cycles=%0d data=%h", cyc, wb_data);
        tick();
        stub_val = 32'h00000001;
        issue_and_wait(4'b1010, 32'h3F800000, 32'h40000000, 5'd9, cyc, held, rlow);
        total_cnt++;
        if (cyc !== 1) $display("FAIL flt_exec_cycles: got %0d want 1", cyc); else pass_cnt++;
        total_cnt++;
        if (wb_data !== 32'h1 || wb_to_int !== 1'b1 || wb_err !== 2'b00)
            $display("FAIL flt_wb: got %h int=%b err=%b want 1 int=1 err=00", wb_data, wb_to_int, wb_err);
        else pass_cnt++;
        $display("flt: cycles=%0d data=%h to_int=%b", cyc, wb_data, wb_to_int);
        tick();
    endtask

    task automatic test_back_to_back();
        int cyc; bit held; bit rlow;
        wb_ready = 1'b1;
        stub_val = 32'h40C00000;
        issue_and_wait(4'b0010, 32'h40000000, 32'h40400000, 5'd4, cyc, held, rlow);
        total_cnt++;
        if (cyc !== 4 || wb_data !== 32'h40C00000)
            $display("FAIL b2b_first: got cycles=%0d data=%h want 4/40c00000", cyc, wb_data); else pass_cnt++;
        total_cnt++;
        if (fpu_op !== 4'hF) $display("FAIL b2b_gap_nop: got %h want f", fpu_op); else pass_cnt++;
        // Offer fsgnjn while the fmul result is being consumed.
        req_valid = 1'b1; req_op = 4'b0110;
        req_src0 = 32'h3F800000; req_src1 = 32'hBF800000; req_rd = 5'd5;
        stub_val = 32'h3F800000;
        #1;
        total_cnt++;
        if (req_ready !== 1'b1) $display("FAIL b2b_ready_in_wb: got %b want 1", req_ready); else pass_cnt++;
        tick();
        req_valid = 1'b0;
        total_cnt++;
        if (busy !== 1'b1 || wb_valid !== 1'b0 || fpu_op !== 4'b0110)
            $display("FAIL b2b_second_exec: got busy=%b valid=%b op=%h want 1/0/6", busy, wb_valid, fpu_op);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h3F800000 || wb_rd !== 5'd5)
            $display("FAIL b2b_second_wb: got valid=%b data=%h rd=%0d want 1/3f800000/5", wb_valid, wb_data, wb_rd);
        else pass_cnt++;
        $display("back_to_back: second data=%h rd=%0d", wb_data, wb_rd);
        tick();
    endtask

    task automatic test_illegal();
        int cyc; bit held; bit rlow;
        wb_ready = 1'b0;
        issue_and_wait(4'b1100, 32'h12345678, 32'h9ABCDEF0, 5'd2, cyc, held, rlow);
        total_cnt++;
        if (cyc !== 0) $display("FAIL illegal_exec_cycles: got %0d want 0", cyc); else pass_cnt++;
        total_cnt++;
        if (wb_data !== 32'h0 || wb_err !== 2'b01 || wb_to_int !== 1'b0 || wb_rd !== 5'd2)
            $display("FAIL illegal_wb: got data=%h err=%b int=%b rd=%0d want 0/01/0/2", wb_data, wb_err, wb_to_int, wb_rd);
        else pass_cnt++;
        $display("illegal: err=%b", wb_err);
        wb_ready = 1'b1;
        tick();
    endtask

    task automatic test_wb_stall();
        int cyc; bit held; bit rlow; bit stable; bit noready; bit nop;
        wb_ready = 1'b0;
        stub_val = 32'h41200000;
        issue_and_wait(4'b0010, 32'h40000000, 32'h40A00000, 5'd12, cyc, held, rlow);
        total_cnt++;
        if (cyc !== 4) $display("FAIL stall_exec_cycles: got %0d want 4", cyc); else pass_cnt++;
        req_valid = 1'b1; req_op = 4'b0000; req_src0 = 32'h1; req_src1 = 32'h2; req_rd = 5'd1;
        stable = 1'b1; noready = 1'b1; nop = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (wb_valid !== 1'b1 || wb_data !== 32'h41200000 || wb_rd !== 5'd12) stable = 1'b0;
            if (req_ready !== 1'b0) noready = 1'b0;
            if (fpu_op !== 4'hF) nop = 1'b0;
            tick();
        end
        total_cnt++;
        if (!stable) $display("FAIL stall_wb_stable: got 0 want 1"); else pass_cnt++;
        total_cnt++;
        if (!noready) $display("FAIL stall_req_ready_low: got 0 want 1"); else pass_cnt++;
        total_cnt++;
        if (!nop) $display("FAIL stall_fpu_nop: got 0 want 1"); else pass_cnt++;
        req_valid = 1'b0;
        wb_ready = 1'b1;
        tick();
        total_cnt++;
        if (wb_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL stall_release: got valid=%b busy=%b want 0/0", wb_valid, busy); else pass_cnt++;
        $display("wb_stall: released");
    endtask

    task automatic test_timeout();
        int cyc; bit held; bit rlow;
        wb_ready = 1'b0;
        stub_hang = 1'b1;
        issue_and_wait(4'b0100, 32'h41100000, 32'h0, 5'd8, cyc, held, rlow);
        total_cnt++;
        if (cyc !== 15) $display("FAIL timeout_exec_cycles: got %0d want 15", cyc); else pass_cnt++;
        total_cnt++;
        if (wb_err !== 2'b10 || wb_data !== 32'h0 || wb_rd !== 5'd8)
            $display("FAIL timeout_wb: got err=%b data=%h rd=%0d want 10/0/8", wb_err, wb_data, wb_rd); else pass_cnt++;
        $display("timeout: cycles=%0d err=%b", cyc, wb_err);
        stub_hang = 1'b0;
        wb_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid_exec();
        int cyc; bit held; bit rlow;
        wb_ready = 1'b1;
        stub_val = 32'h40400000;
        req_valid = 1'b1; req_op = 4'b0011;
        req_src0 = 32'h40C00000; req_src1 = 32'h40000000; req_rd = 5'd10;
        tick();
        req_valid = 1'b0;
        repeat (4) tick();
        total_cnt++;
        if (busy !== 1'b1 || fpu_op !== 4'b0011)
            $display("FAIL midreset_in_exec: got busy=%b op=%h want 1/3", busy, fpu_op); else pass_cnt++;
        rstn = 1'b0;
        tick();
        total_cnt++;
        if (wb_valid !== 1'b0 || busy !== 1'b0 || fpu_op !== 4'hF || fpu_src0 !== 32'h0)
            $display("FAIL midreset_cleared: got valid=%b busy=%b op=%h src0=%h want 0/0/f/0",
                     wb_valid, busy, fpu_op, fpu_src0);
        else pass_cnt++;
        rstn = 1'b1;
        stub_val = 32'h40800000;
        issue_and_wait(4'b0000, 32'h40400000, 32'h3F800000, 5'd11, cyc, held, rlow);
        total_cnt++;
        if (cyc !== 4 || wb_data !== 32'h40800000 || wb_rd !== 5'd11 || wb_err !== 2'b00)
            $display("FAIL midreset_fadd: got cycles=%0d data=%h rd=%0d err=%b want 4/40800000/11/00",
                     cyc, wb_data, wb_rd, wb_err);
        else pass_cnt++;
        $display("reset_mid_exec: fadd after reset cycles=%0d data=%h", cyc, wb_data);
        tick();
    endtask

    initial begin
        test_reset();
        test_fadd();
        test_fdiv_flt();
        test_back_to_back();
        test_illegal();
        test_wb_stall();
        test_timeout();
        test_reset_mid_exec();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
- Issue/sequencing stage directly upstream of the `fpu` block.
- Accepts one FP request at a time from the core's execute stage over a valid/ready handshake.
- Holds operands and opcode stable on the `fpu` inputs until `fpu` raises `fin`, then captures the result.
- Presents the result to writeback on a second valid/ready handshake, tagged with its destination register.

Parameters:
- TIMEOUT, 15, maximum EXEC cycles before the request is aborted with an error.
- RD_W, 5, width of the destination register index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle when high together with req_valid.
- req_src0  in  32  operand 0.
- req_src1  in  32  operand 1.
- req_op  in  4  fpu opcode (0000 fadd … 1010 flt).
- req_rd  in  RD_W  destination register index.
- fpu_src0  out  32  to fpu.src0.
- fpu_src1  out  32  to fpu.src1.
- fpu_op  out  4  to fpu.fpuop.
- fpu_result  in  32  from fpu.result.
- fpu_fin  in  1  from fpu.fin.
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback consumes the result.
- wb_data  out  32  result value.
- wb_rd  out  RD_W  destination index.
- wb_to_int  out  1  1 = destination is the integer register file (ops 1000–1010); 0 = FP register file.
- wb_err  out  2  bit0 = illegal opcode, bit1 = timeout.
- busy  out  1  high in EXEC or WB; used by the hazard unit.

Behaviour:
- States: IDLE, EXEC, WB.
  - EXEC and WB lasting more than one cycle is normal.
- Reset (rstn=0 at a clock edge, including mid-EXEC or mid-WB): state goes to IDLE and the request is dropped.
  - All latches are zeroed; wb_valid=0, wb_err=0, busy=0, cycle counter=0.
  - fpu_op=1111 and fpu_src0/fpu_src1=0.
  - req_ready=0 while rstn=0.
- fpu_op is 1111 (NOP) whenever state != EXEC.
  - Required: fpu starts its multi-cycle counter on any op 0000–0100 while its own counter is 0, so idle operands must never look like a real op.
  - With NOP, fpu returns fin=1 and its counter self-clears.
- req_ready = (state==IDLE) | (state==WB & wb_ready).
  - Back-to-back acceptance is allowed in the same cycle the previous result is consumed.
- Accept (req_valid & req_ready): latch src0, src1, op, rd; compute wb_to_int = (op in 1000..1010).
  - Legal op (0000–1010): go to EXEC, clear the counter.
  - Illegal op (1011–1111): skip EXEC; go to WB with wb_data=0 and wb_err=01.
- EXEC:
  - Drive the latched operands and op to fpu; increment the counter each cycle.
  - fpu_fin=1: capture fpu_result into wb_data in the same edge; go to WB with wb_err=00.
  - Counter == TIMEOUT-1 without fin: go to WB with wb_data=0 and wb_err=10.
  - fin takes priority over timeout on the same cycle.
- EXEC length (fin seen in EXEC cycle N, 1-based):
  - ops 0101–1010: N=1.
  - fadd/fsub/fmul: N=4.
  - fsqrt: N=9.
  - fdiv: N=11.
  - wb_valid rises the cycle after fin.
- WB:
  - wb_valid=1; wb_data, wb_rd, wb_to_int and wb_err are stable until the handshake.
  - wb_valid & wb_ready: go to IDLE, or to EXEC/WB if a new request is accepted in the same cycle.
- Between accept and writeback, outputs depend only on latched values; req_* may change freely once accepted.
- busy = (state != IDLE).

Test Plan:
- fadd 0x3F800000 + 0x40000000, rd=3, wb_ready=1 → fpu_op=0000 held for 4 EXEC cycles; wb_valid one cycle later; wb_data=0x40400000, wb_rd=3, wb_to_int=0, wb_err=0.
- fdiv 0x40C00000 / 0x40000000 → 11 EXEC cycles, req_ready=0 throughout, wb_data=0x40400000; flt 1.0<2.0 → wb_data=1, wb_to_int=1, EXEC=1 cycle.
- Back-to-back: fsgnjn issued while the previous result sits in WB with wb_ready=1 → accepted in the same cycle, no idle bubble; fpu_op returns to 1111 between the two ops.
- wb_ready held low 5 cycles after fmul completes → wb_valid/wb_data stable, req_ready=0, fpu_op=1111; release → handshake completes, state goes to IDLE.
- req_op=1100 → no EXEC; wb_valid next cycle, wb_data=0, wb_err=01; stubbed fpu never raising fin on fsqrt → wb_err=10 after exactly 15 EXEC cycles.
- rstn=0 during EXEC cycle 5 of fdiv → next edge: IDLE, wb_valid=0, busy=0, fpu_op=1111; a new fadd after reset completes normally with correct latency.
